// File: rtl/demux_bank.sv
// Registered one-to-many demultiplexer and word bank: stores one word per handshake into a
// selected or auto-pointed slot, freezes when every slot is written, and presents a flat vector.
module demux_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 128,
    localparam int unsigned SelW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic                    iAuto,
    input  logic [SelW-1:0]         iSelect,
    input  logic [WIDTH-1:0]        iData,
    input  logic                    iClear,
    input  logic                    iRelease,
    output logic [SIZE*WIDTH-1:0]   oData,
    output logic [SIZE-1:0]         oMask,
    output logic                    oFull,
    output logic [SelW-1:0]         oPtr,
    output logic                    oErr
);

    typedef enum logic {StFill, StHold} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       data_q [SIZE];
    logic [SIZE-1:0]        mask_q, mask_d;
    logic [SelW-1:0]        ptr_q, ptr_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   in_range;
    logic                   write_en;
    logic [SelW-1:0]        target;

    always_comb begin
        accept   = iValid && (state_q == StFill);
        target   = iAuto ? ptr_q : iSelect;
        in_range = {1'b0, target} < (SelW + 1)'(SIZE);
        // A clear in the same cycle discards the write entirely.
        write_en = accept && !iClear && in_range;
    end

    always_comb begin
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        state_d = state_q;
        if (iClear) begin
            mask_d  = '0;
            ptr_d   = '0;
            state_d = StFill;
        end else if (state_q == StHold) begin
            if (iRelease) begin
                mask_d  = '0;
                ptr_d   = '0;
                state_d = StFill;
            end
        end else if (accept) begin
            if (in_range) begin
                mask_d[target] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            if (iAuto) begin
                ptr_d = (ptr_q == SelW'(SIZE - 1)) ? '0 : ptr_q + SelW'(1);
            end
            if (&mask_d) begin
                state_d = StHold;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= StFill;
            mask_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int gi = 0; gi < int'(SIZE); gi++) begin
                data_q[gi] <= '0;
            end
        end else begin
            for (int gi = 0; gi < int'(SIZE); gi++) begin
                if (write_en && (target == SelW'(gi))) begin
                    data_q[gi] <= iData;
                end
            end
        end
    end

    always_comb begin
        for (int gi = 0; gi < int'(SIZE); gi++) begin
            oData[gi*WIDTH +: WIDTH] = data_q[gi];
        end
    end

    assign oReady = (state_q == StFill) && !iRst;
    assign oFull  = (state_q == StHold);
    assign oMask  = mask_q;
    assign oPtr   = ptr_q;
    assign oErr   = err_q;

endmodule
